// File: rtl/weight_pkg.sv
// Shared definitions for the weight loader: bus widths, the loader state
// encoding and a small helper for sizing index counters.
package weight_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   // Width of an index that must address 'entries' slots (at least one bit).
   function automatic int idx_width(input int entries);
      return (entries > 1) ? $clog2(entries) : 1;
   endfunction

endpackage

// File: rtl/tile_buffer.sv
// N x N weight tile storage. Words arrive in row-major order through the
// write port. The read port is addressed in column-major order, so reading
// k = 0,1,2,... walks the tile transposed. A same-cycle write to the slot
// being read is forwarded so the read never sees stale data.
module tile_buffer
   import weight_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N * N)
)
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   localparam int ENTRIES = N * N;

   logic [DATA_W-1:0] tile [ENTRIES];
   logic [IDX_W-1:0]  rd_flat;

   // Row-major store: word i is row i/N, column i%N, which is flat slot i.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tile[wr_idx] <= wr_data;
      end
   end

   // Column-major fetch: read index k selects row k%N, column k/N.
   always_comb begin
      rd_flat = IDX_W'((int'(rd_idx) % N) * N + int'(rd_idx) / N);
      rd_data = tile[rd_flat];
      if (wr_en && (wr_idx == rd_flat)) begin
         rd_data = wr_data;
      end
   end

endmodule

// File: rtl/weight_loader.sv
// Weight loader: collects an N x N tile of weights from a valid/ready stream
// and writes it transposed into weight memory starting at base_addr.
// Optional feature macro: WEIGHT_LOADER_BOUNDS_EN enables a start-time bounds
// check against MEM_DEPTH; a failing tile raises the sticky err flag and
// skips straight to DONE without any memory writes.
module weight_loader
   import weight_pkg::*;
#(
   parameter int N         = 2,
   parameter int MEM_DEPTH = 256
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int ENTRIES = N * N;
   localparam int CNT_W   = idx_width(ENTRIES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ENTRIES - 1);
   localparam logic [31:0] DEPTH_MAX = 32'(MEM_DEPTH - 1);

`ifdef WEIGHT_LOADER_BOUNDS_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   loader_state_t     state;
   loader_state_t     next_state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] base_d;
   logic              err_d;
   logic              accept;
   logic [31:0]       last_addr;
   logic              bounds_fail;
   logic              in_ready_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic              busy_d;
   logic              done_d;
   logic [DATA_W-1:0] rd_data;

   // Last address the tile would touch, computed without wrap so that a
   // tile running past the top of memory is caught by the bounds check.
   assign last_addr   = {{(32 - ADDR_W){1'b0}}, base_addr} + 32'(ENTRIES - 1);
   assign bounds_fail = BOUNDS_EN && (last_addr > DEPTH_MAX);

   // A word is taken only when the loader advertises ready and data is valid.
   assign accept = in_ready && in_valid;

   // The shared counter indexes incoming words during FILL and writes
   // during WRITE; the buffer is read at the index of the upcoming write.
   tile_buffer #(
      .N     (N),
      .IDX_W (CNT_W)
   ) u_tile_buffer (
      .clk     (clk),
      .wr_en   (accept),
      .wr_idx  (cnt),
      .wr_data (in_data),
      .rd_idx  (cnt_d),
      .rd_data (rd_data)
   );

   // State, counter, latched base and all outputs are registered here so
   // that reset clears every output immediately and no input reaches an
   // output combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         base_q    <= '0;
         err       <= 1'b0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= cnt_d;
         base_q    <= base_d;
         err       <= err_d;
         in_ready  <= in_ready_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   // Next-state logic: start is honoured only in IDLE, FILL advances on
   // each accepted word, WRITE advances every cycle, DONE lasts one cycle.
   always_comb begin
      next_state = state;
      cnt_d      = cnt;
      base_d     = base_q;
      err_d      = err;
      case (state)
         IDLE: begin
            if (start) begin
               base_d     = base_addr;
               cnt_d      = '0;
               err_d      = bounds_fail;
               next_state = bounds_fail ? DONE : FILL;
            end
         end
         FILL: begin
            if (accept) begin
               if (cnt == LAST) begin
                  cnt_d      = '0;
                  next_state = WRITE;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         WRITE: begin
            if (cnt == LAST) begin
               cnt_d      = '0;
               next_state = DONE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state; the
   // memory bus is held at zero whenever no write is being issued.
   always_comb begin
      in_ready_d  = (next_state == FILL);
      mem_we_d    = (next_state == WRITE);
      busy_d      = (next_state != IDLE);
      done_d      = (next_state == DONE);
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if (mem_we_d) begin
         mem_addr_d  = base_d + ADDR_W'(cnt_d);
         mem_wdata_d = rd_data;
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader. Expected memory writes, latencies
// and flags are computed from the tile-transpose rules with plain arithmetic
// on the words the bench itself sent.
module tb_weight_loader;

   localparam int N         = 2;
   localparam int NN        = N * N;
   localparam int MEM_DEPTH = 256;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [12:0] base_addr;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   logic [15:0] tile_words [NN];
   int          checks = 0;
   int          errors = 0;

   weight_loader #(
      .N         (N),
      .MEM_DEPTH (MEM_DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic bit expectOob(input logic [12:0] base);
`ifdef WEIGHT_LOADER_BOUNDS_EN
      return (int'(base) + NN - 1) > (MEM_DEPTH - 1);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] expAddr(input logic [12:0] base, input int k);
      return 32'((int'(base) + k) % 8192);
   endfunction

   function automatic logic [31:0] expData(input int k);
      return 32'(tile_words[(k % N) * N + k / N]);
   endfunction

   // Runs one tile: pulses start, streams words (random or forced gaps),
   // checks every write against the transpose model and the done timing.
   task automatic applyStimulus(input logic [12:0] base, input int valid_pct,
                                input int gap_after, input bit restart,
                                input bit fixed_words);
      int accepted    = 0;
      int writes      = 0;
      int last_accept = 0;
      int done_cycle  = -1;
      int gap_used    = 0;
      bit finished    = 1'b0;
      bit pulsed      = 1'b0;
      bit oob;
      logic err_at_done = 1'b0;

      oob = expectOob(base);
      if (!fixed_words) begin
         for (int i = 0; i < NN; i++) tile_words[i] = 16'($urandom);
      end

      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = base;
      in_valid  = 1'b0;

      for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (restart && !pulsed && writes == 2) begin
            start     = 1'b1;
            base_addr = 13'h0100;
            pulsed    = 1'b1;
         end
         if (accepted >= NN) begin
            in_valid = 1'b0;
         end else if (accepted == gap_after && gap_used < 2) begin
            in_valid = 1'b0;
            gap_used++;
         end else begin
            in_valid = ($urandom_range(99) < valid_pct);
         end
         in_data = in_valid ? tile_words[accepted] : 16'($urandom);

         @(negedge clk);
         if (in_ready && in_valid) begin
            accepted++;
            last_accept = cyc;
         end
         if (mem_we) begin
            if (writes < NN) begin
               checkOutput("wr_addr", 32'(mem_addr), expAddr(base, writes));
               checkOutput("wr_data", 32'(mem_wdata), expData(writes));
               checkOutput("wr_cycle", cyc, last_accept + 1 + writes);
            end else begin
               checkOutput("write_count", writes + 1, NN);
            end
            writes++;
         end
         if (done) begin
            done_cycle  = cyc;
            err_at_done = err;
            finished    = 1'b1;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;

      checkOutput("done_seen", 32'(finished), 32'd1);
      if (oob) begin
         checkOutput("oob_done_cycle", done_cycle, 1);
         checkOutput("oob_writes", writes, 0);
         checkOutput("oob_err", 32'(err_at_done), 32'd1);
      end else begin
         checkOutput("write_total", writes, NN);
         checkOutput("done_cycle", done_cycle, last_accept + NN + 1);
         checkOutput("err_clear", 32'(err_at_done), 32'd0);
      end

      @(posedge clk);
      @(negedge clk);
      checkOutput("after_busy", 32'(busy), 32'd0);
      checkOutput("after_done", 32'(done), 32'd0);
      checkOutput("err_sticky", 32'(err), 32'(oob));
   endtask

   // Asserts reset after two writes and confirms everything goes quiet.
   task automatic applyResetMidWrite();
      int writes = 0;
      for (int i = 0; i < NN; i++) tile_words[i] = 16'($urandom);
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = 13'h0040;
      for (int cyc = 1; cyc <= 40 && writes < 2; cyc++) begin
         @(posedge clk); #1;
         start    = 1'b0;
         in_valid = (cyc <= NN);
         in_data  = (cyc <= NN) ? tile_words[cyc - 1] : 16'h0;
         @(negedge clk);
         if (mem_we) begin
            checkOutput("rst_pre_addr", 32'(mem_addr), expAddr(13'h0040, writes));
            writes++;
         end
      end
      checkOutput("rst_pre_writes", writes, 2);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("rst_hold_we", 32'(mem_we), 32'd0);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("post_rst_we", 32'(mem_we), 32'd0);
         checkOutput("post_rst_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      in_valid  = 1'b0;
      in_data   = '0;

      #3;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Valid data while idle must be ignored.
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      repeat (4) begin
         @(negedge clk);
         checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
         checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
         checkOutput("idle_busy", 32'(busy), 32'd0);
      end
      in_valid = 1'b0;

      // Directed tile with continuous stream.
      tile_words[0] = 16'd3;
      tile_words[1] = 16'd4;
      tile_words[2] = 16'd5;
      tile_words[3] = 16'd6;
      applyStimulus(13'h000F, 100, -1, 1'b0, 1'b1);
      // Same tile with a two-cycle gap between the second and third word.
      applyStimulus(13'h000F, 100, 2, 1'b0, 1'b1);
      // Start pulsed during WRITE must not disturb the load.
      applyStimulus(13'h000F, 100, -1, 1'b1, 1'b1);
      // Top-of-memory tile: wraps, or is rejected when bounds checking is on.
      applyStimulus(13'h1FFF, 100, -1, 1'b0, 1'b0);

      applyResetMidWrite();
      applyStimulus(13'h0020, 100, -1, 1'b0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         logic [12:0] b;
         if (t % 3 == 0) b = 13'(8192 - 1 - $urandom_range(4));
         else            b = 13'($urandom_range(300));
         applyStimulus(b, 40 + int'($urandom_range(60)), -1, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter: N, default 2, tile dimension (N x N weights per load).
REQ-002 Parameter: MEM_DEPTH, default 256, number of weight-memory words.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a tile load.
REQ-006 base_addr  input  13  first weight-memory address of the tile.
REQ-007 in_valid  input  1  in_data holds a weight.
REQ-008 in_data  input  16  weight word, row-major order.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 mem_we  output  1  weight-memory write strobe.
REQ-011 mem_addr  output  13  weight-memory write address.
REQ-012 mem_wdata  output  16  weight-memory write data.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the final write.
REQ-015 err  output  1  bounds error, sticky until next start (WEIGHT_LOADER_BOUNDS_EN only; tied 0 otherwise).

Function
REQ-016 FSM states: IDLE, FILL, WRITE, DONE.
REQ-017 IDLE: start=1 latches base_addr, clears word counter, moves to FILL next cycle; start in any other state is ignored.
REQ-018 FILL: in_ready=1; a word is accepted only when in_valid and in_ready are both 1 on a rising edge; in_valid low stalls without loss.
REQ-019 Accepted word index i (0..N*N-1) is stored as tile element row i/N, column i%N.
REQ-020 After word N*N-1 is accepted, next state is WRITE; in_ready=0 in all states except FILL.
REQ-021 WRITE: one write per cycle, N*N consecutive cycles, mem_we=1 each cycle.
REQ-022 Write k (0..N*N-1): mem_addr = base_addr + k, mem_wdata = tile[row k%N][col k/N] (transposed, column-major).
REQ-023 Address addition is 13-bit, wraps modulo 8192.
REQ-024 After write N*N-1, state DONE for exactly one cycle with done=1, then IDLE.
REQ-025 Latency with in_valid held high: start at cycle 0, words accepted cycles 1..N*N, writes cycles N*N+1..2*N*N, done at cycle 2*N*N+1.
REQ-026 mem_addr and mem_wdata are 0 whenever mem_we=0.
REQ-027 Outputs are registered; no combinational path from inputs to outputs except none (in_ready derives from state only).

Reset
REQ-028 rst_n low forces state IDLE and in_ready, mem_we, mem_addr, mem_wdata, busy, done, err to 0 immediately, regardless of clock.
REQ-029 Reset mid-FILL or mid-WRITE abandons the tile; no further writes occur; tile buffer contents need not be cleared.

Configuration
REQ-030 Macro WEIGHT_LOADER_BOUNDS_EN defined: at start, if base_addr + N*N - 1 > MEM_DEPTH - 1, err=1, no FILL, no writes, state goes directly to DONE (done pulses); otherwise err=0.
REQ-031 Macro undefined: no bounds check, err constant 0, addresses wrap per REQ-023.

Structure
REQ-032 Shared package weight_pkg holds ADDR_W=13, DATA_W=16, and the loader state enum typedef.
REQ-033 One sub-module tile_buffer (N x N register array, row-major write port, column-major read port) is natural; FSM and counters stay in weight_loader.

Verification
REQ-034 N=2, start with base_addr=0x000F, stream 3,4,5,6 with in_valid held -> writes (0x000F,3),(0x0010,5),(0x0011,4),(0x0012,6) in cycles 5-8, done at cycle 9.
REQ-035 Same stream with in_valid low for 2 cycles between words 2 and 3 -> identical write sequence, shifted by 2 cycles, no word lost or duplicated.
REQ-036 start pulsed again during WRITE with base_addr=0x0100 -> ignored; writes complete at 0x000F..0x0012.
REQ-037 rst_n low after 2 writes -> all outputs 0 immediately, no further mem_we; new start afterwards loads a fresh tile correctly.
REQ-038 base_addr=0x1FFF without macro -> writes to 0x1FFF,0x0000,0x0001,0x0002; with WEIGHT_LOADER_BOUNDS_EN and MEM_DEPTH=256 -> err=1, no writes, done pulses one cycle after start.
REQ-039 in_valid high while IDLE with no start -> in_ready=0, no writes, busy=0.
